// File: rtl/ddr5_dimm_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// ddr5_dimm_cmd_responder_if
// Command/response bundle between a DDR5 command issuer and the DIMM-side
// responder.
//   cmd[3:0]       command code (NOP, ACT0/1, RD0/1, WR0/1, PRE, REF)
//   bg[2:0]        bank group
//   ba[1:0]        bank within the group
//   row[15:0]      row address (ACT halves)
//   col[5:0]       column address (RD/WR halves)
//   rd_valid       one-cycle read-return pulse
//   rd_tag[26:0]   {bg, ba, open row, col} of the returning read
//   wr_done        one-cycle write-complete pulse
//   wr_tag[26:0]   same layout as rd_tag
//   err_valid      one-cycle violation pulse
//   err_code[1:0]  1 PAIR, 2 STATE, 3 TIMING
// Modports: master = command issuer, slave = responder.
// ---------------------------------------------------------------------------
interface ddr5_dimm_cmd_responder_if;
    logic [3:0]  cmd;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [5:0]  col;
    logic        rd_valid;
    logic [26:0] rd_tag;
    logic        wr_done;
    logic [26:0] wr_tag;
    logic        err_valid;
    logic [1:0]  err_code;

    modport master (
        output cmd, bg, ba, row, col,
        input  rd_valid, rd_tag, wr_done, wr_tag, err_valid, err_code
    );

    modport slave (
        input  cmd, bg, ba, row, col,
        output rd_valid, rd_tag, wr_done, wr_tag, err_valid, err_code
    );
endinterface

// File: rtl/ddr5_dimm_cmd_responder.sv
// ---------------------------------------------------------------------------
// ddr5_dimm_cmd_responder
// DIMM-side responder and protocol checker for the two-cycle DDR5 command
// stream. Pairs command halves, tracks state/timers for 8 bank groups x 4
// banks plus a global refresh window, returns read tags after TCL and write
// completions after TCWL, and flags PAIR / STATE / TIMING violations.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   ddr5_dimm_cmd_responder_if.slave (command inputs, registered
//         rd/wr/err outputs)
//
// Configuration macro: DIMM_RESP_STRICT_EN
//   defined   : every violating command is flagged and dropped.
//   undefined : violations are flagged, but TIMING-only violations still
//               execute (early RD/WR queued, early ACT/PRE take effect);
//               STATE violations are always dropped.
//
// Timing: a command sampled at edge k that is flagged shows err_valid right
// after edge k. RD1 at edge k shows rd_valid right after edge k+TCL-1 (TCL
// register stages total, the last being the output register); WR1 likewise
// with TCWL. Timers are loaded with T-1 and the state moves on the edge the
// timer drops from 1 to 0, so the follow-up command is legal T edges later.
// TRCD, TRP and TRFC must be >= 2; TCL and TCWL must be >= 2.
// ---------------------------------------------------------------------------
module ddr5_dimm_cmd_responder #(
    parameter int TRCD = 4,
    parameter int TRP  = 4,
    parameter int TCL  = 6,
    parameter int TCWL = 4,
    parameter int TRFC = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    ddr5_dimm_cmd_responder_if.slave     bus
);

`ifdef DIMM_RESP_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    localparam int TW = 8;

    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_ACT0 = 4'd1;
    localparam logic [3:0] C_ACT1 = 4'd2;
    localparam logic [3:0] C_RD0  = 4'd3;
    localparam logic [3:0] C_RD1  = 4'd4;
    localparam logic [3:0] C_WR0  = 4'd5;
    localparam logic [3:0] C_WR1  = 4'd6;
    localparam logic [3:0] C_PRE  = 4'd7;
    localparam logic [3:0] C_REF  = 4'd8;

    localparam logic [1:0] E_NONE   = 2'd0;
    localparam logic [1:0] E_PAIR   = 2'd1;
    localparam logic [1:0] E_STATE  = 2'd2;
    localparam logic [1:0] E_TIMING = 2'd3;

    typedef enum logic [1:0] {
        B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING
    } bank_st_t;

    typedef enum logic {WAIT_FIRST, WAIT_SECOND} pair_st_t;

    // Bank bookkeeping
    bank_st_t        r_bank_st  [32];
    logic [TW-1:0]   r_bank_tmr [32];
    logic [15:0]     r_bank_row [32];
    logic            r_ref_busy;
    logic [TW-1:0]   r_ref_tmr;

    // Pairing FSM and latched first half
    pair_st_t        r_pair_st;
    logic [3:0]      r_l_cmd;
    logic [2:0]      r_l_bg;
    logic [1:0]      r_l_ba;
    logic [15:0]     r_l_row;
    logic [5:0]      r_l_col;
    logic            r_l_bad;

    // Latency pipes (stage 0 .. T-2); the output register is the last stage
    logic            r_rd_vld_p [TCL-1];
    logic [26:0]     r_rd_tag_p [TCL-1];
    logic            r_wr_vld_p [TCWL-1];
    logic [26:0]     r_wr_tag_p [TCWL-1];

    logic            r_rd_valid;
    logic [26:0]     r_rd_tag;
    logic            r_wr_done;
    logic [26:0]     r_wr_tag;
    logic            r_err_valid;
    logic [1:0]      r_err_code;

    logic [4:0]      w_bank;
    bank_st_t        w_st;
    logic            w_all_idle;
    logic            w_pair_err, w_state_err, w_time_err;
    logic            w_latch, w_latch_bad, w_match, w_exec;
    logic            w_do_act, w_do_rd, w_do_wr, w_do_pre, w_do_ref;
    pair_st_t        w_pair_nxt;
    logic [26:0]     w_new_tag;

    assign w_bank    = {bus.bg, bus.ba};
    assign w_st      = r_bank_st[w_bank];
    assign w_new_tag = {bus.bg, bus.ba, r_bank_row[w_bank], bus.col};

    always_comb begin
        w_all_idle = 1'b1;
        for (int b = 0; b < 32; b++) begin
            if (r_bank_st[b] != B_IDLE) w_all_idle = 1'b0;
        end
    end

    // Decode: classify the sampled command and decide what it may change.
    always_comb begin
        w_pair_err  = 1'b0;
        w_state_err = 1'b0;
        w_time_err  = 1'b0;
        w_latch     = 1'b0;
        w_latch_bad = 1'b0;
        w_match     = 1'b0;
        w_exec      = 1'b0;
        w_do_act    = 1'b0;
        w_do_rd     = 1'b0;
        w_do_wr     = 1'b0;
        w_do_pre    = 1'b0;
        w_do_ref    = 1'b0;
        w_pair_nxt  = r_pair_st;
        if (r_pair_st == WAIT_FIRST) begin
            case (bus.cmd)
                C_NOP: ;
                C_ACT0: begin
                    // Bank state for ACT is judged at ACT1.
                    w_time_err  = r_ref_busy;
                    w_latch     = 1'b1;
                    w_latch_bad = w_time_err & STRICT;
                    w_pair_nxt  = WAIT_SECOND;
                end
                C_RD0, C_WR0: begin
                    w_state_err = (w_st == B_IDLE) || (w_st == B_PRECHARGING);
                    w_time_err  = r_ref_busy || (w_st == B_ACTIVATING);
                    // A rejected first half is still latched (marked bad) so
                    // its matching second half is consumed silently.
                    w_latch     = 1'b1;
                    w_latch_bad = w_state_err | (w_time_err & STRICT);
                    w_pair_nxt  = WAIT_SECOND;
                end
                C_PRE: begin
                    w_time_err = r_ref_busy || (w_st == B_ACTIVATING) ||
                                 (w_st == B_PRECHARGING);
                    w_do_pre   = !w_time_err || !STRICT;
                end
                C_REF: begin
                    w_state_err = !w_all_idle;
                    w_time_err  = r_ref_busy;
                    w_do_ref    = !w_state_err && (!w_time_err || !STRICT);
                end
                default: w_pair_err = 1'b1;
            endcase
        end else begin
            // Second halves are encoded as first half + 1.
            w_match = (bus.cmd == r_l_cmd + 4'd1) && (bus.bg == r_l_bg) &&
                      (bus.ba == r_l_ba) &&
                      ((r_l_cmd == C_ACT0) ? (bus.row == r_l_row)
                                           : (bus.col == r_l_col));
            w_pair_nxt = WAIT_FIRST;
            if (!w_match) begin
                w_pair_err = 1'b1;
            end else begin
                w_time_err = r_ref_busy;
                if (bus.cmd == C_ACT1) begin
                    w_state_err = (w_st == B_ACTIVATING) || (w_st == B_ACTIVE);
                    if (w_st == B_PRECHARGING) w_time_err = 1'b1;
                end
                w_exec   = !r_l_bad && !w_state_err && (!w_time_err || !STRICT);
                w_do_act = w_exec && (bus.cmd == C_ACT1);
                w_do_rd  = w_exec && (bus.cmd == C_RD1);
                w_do_wr  = w_exec && (bus.cmd == C_WR1);
            end
        end
    end

    // Stage p0: control state, pipe valids and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair_st   <= WAIT_FIRST;
            r_l_bad     <= 1'b0;
            r_ref_busy  <= 1'b0;
            r_ref_tmr   <= '0;
            for (int b = 0; b < 32; b++) begin
                r_bank_st[b]  <= B_IDLE;
                r_bank_tmr[b] <= '0;
            end
            for (int i = 0; i < TCL - 1; i++)  r_rd_vld_p[i] <= 1'b0;
            for (int i = 0; i < TCWL - 1; i++) r_wr_vld_p[i] <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_tag    <= '0;
            r_wr_done   <= 1'b0;
            r_wr_tag    <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= E_NONE;
        end else begin
            r_pair_st <= w_pair_nxt;
            if (w_latch) r_l_bad <= w_latch_bad;

            for (int b = 0; b < 32; b++) begin
                if (r_bank_st[b] == B_ACTIVATING || r_bank_st[b] == B_PRECHARGING) begin
                    if (r_bank_tmr[b] <= TW'(1)) begin
                        r_bank_tmr[b] <= '0;
                        r_bank_st[b]  <= (r_bank_st[b] == B_ACTIVATING) ? B_ACTIVE : B_IDLE;
                    end else begin
                        r_bank_tmr[b] <= r_bank_tmr[b] - TW'(1);
                    end
                end
            end
            if (w_do_act) begin
                r_bank_st[w_bank]  <= B_ACTIVATING;
                r_bank_tmr[w_bank] <= TW'(TRCD - 1);
            end
            // PRE to an IDLE bank is a legal no-op.
            if (w_do_pre && w_st != B_IDLE) begin
                r_bank_st[w_bank]  <= B_PRECHARGING;
                r_bank_tmr[w_bank] <= TW'(TRP - 1);
            end

            if (r_ref_busy) begin
                if (r_ref_tmr <= TW'(1)) begin
                    r_ref_busy <= 1'b0;
                    r_ref_tmr  <= '0;
                end else begin
                    r_ref_tmr <= r_ref_tmr - TW'(1);
                end
            end
            if (w_do_ref) begin
                r_ref_busy <= 1'b1;
                r_ref_tmr  <= TW'(TRFC - 1);
            end

            r_rd_vld_p[0] <= w_do_rd;
            for (int i = 1; i < TCL - 1; i++) r_rd_vld_p[i] <= r_rd_vld_p[i-1];
            r_wr_vld_p[0] <= w_do_wr;
            for (int i = 1; i < TCWL - 1; i++) r_wr_vld_p[i] <= r_wr_vld_p[i-1];

            r_rd_valid <= r_rd_vld_p[TCL-2];
            r_rd_tag   <= r_rd_vld_p[TCL-2] ? r_rd_tag_p[TCL-2] : '0;
            r_wr_done  <= r_wr_vld_p[TCWL-2];
            r_wr_tag   <= r_wr_vld_p[TCWL-2] ? r_wr_tag_p[TCWL-2] : '0;

            r_err_valid <= w_pair_err | w_state_err | w_time_err;
            r_err_code  <= w_pair_err  ? E_PAIR  :
                           w_state_err ? E_STATE :
                           w_time_err  ? E_TIMING : E_NONE;
        end
    end

    // Stage p0 data: latched half, open rows and tag shift (no reset needed;
    // the valids above qualify everything).
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_l_cmd <= bus.cmd;
            r_l_bg  <= bus.bg;
            r_l_ba  <= bus.ba;
            r_l_row <= bus.row;
            r_l_col <= bus.col;
        end
        if (w_do_act) r_bank_row[w_bank] <= bus.row;
        r_rd_tag_p[0] <= w_new_tag;
        for (int i = 1; i < TCL - 1; i++) r_rd_tag_p[i] <= r_rd_tag_p[i-1];
        r_wr_tag_p[0] <= w_new_tag;
        for (int i = 1; i < TCWL - 1; i++) r_wr_tag_p[i] <= r_wr_tag_p[i-1];
    end

    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_tag    = r_rd_tag;
    assign bus.wr_done   = r_wr_done;
    assign bus.wr_tag    = r_wr_tag;
    assign bus.err_valid = r_err_valid;
    assign bus.err_code  = r_err_code;

endmodule
